// File: rtl/ir_queue.sv
// ir_queue: instruction queue plus instruction register for the multicycle CPU.
// Latency: a pushed word can be loaded into the output register one edge later.
//   With IR_BYPASS_EN defined, an empty queue lets a word go straight into the
//   register on the same edge.
// Backpressure: IReady drops while DEPTH entries are queued. The source holds
//   IDataOut/PC4 until IReady is high, and a push made while full is ignored.
//
// Ports:
//   CLK, Reset (async active-low), Flush (redirect: drop queue, invalidate IR)
//   IDataOut/PC4/IValid/IReady : fetch-side push handshake
//   IRWre                      : pop the head into the output register
//   IRValid, op, rs, rt, rd, Immediate, Sa, JumpPC, InstrPC4 : registered
//                                decode of the current instruction
//   Count                      : queued entries, not counting the output register
//
// Optional build macro: IR_BYPASS_EN (zero-latency load when the queue is empty).

module ir_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Flush,
  input  logic [31:0]       IDataOut,
  input  logic [ADDR_W-1:0] PC4,
  input  logic              IValid,
  output logic              IReady,
  input  logic              IRWre,
  output logic              IRValid,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       Immediate,
  output logic [4:0]        Sa,
  output logic [ADDR_W-1:0] JumpPC,
  output logic [ADDR_W-1:0] InstrPC4,
  output logic [CNT_W-1:0]  Count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Queue storage. It is not reset: an entry is only read after it has been written.
  logic [31:0]       mem_instr_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc4_q   [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Output (instruction) register.
  logic              irvalid_q, irvalid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  logic full;
  logic empty;
  logic bypass_en;
  logic push_en;
  logic pop_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IR_BYPASS_EN
  // If the queue is empty and a pop and a push arrive together, the incoming
  // word goes straight into the output register and is not queued.
  assign bypass_en = IValid && IRWre && empty && !Flush;
`else
  assign bypass_en = 1'b0;
`endif

  // Flush wins over both sides. A bypassed word never enters the queue.
  // Fullness is judged on the registered count, so a pop in the same cycle
  // does not make room for a push.
  assign push_en = IValid && !full && !Flush && !bypass_en;
  assign pop_en  = IRWre && !empty && !Flush;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    irvalid_d = irvalid_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;

    if (Flush) begin
      // Decoded fields keep their last values; only validity is dropped.
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      irvalid_d = 1'b0;
    end else if (bypass_en) begin
      instr_d   = IDataOut;
      pc4_d     = PC4;
      irvalid_d = 1'b1;
    end else begin
      if (push_en) begin
        tail_d = tail_q + PTR_W'(1);
      end

      if (IRWre) begin
        if (pop_en) begin
          instr_d   = mem_instr_q[head_q];
          pc4_d     = mem_pc4_q[head_q];
          irvalid_d = 1'b1;
          head_d    = head_q + PTR_W'(1);
        end else begin
          // A load from an empty queue leaves the fields stale but marks them invalid.
          irvalid_d = 1'b0;
        end
      end

      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem_instr_q[tail_q] <= IDataOut;
      mem_pc4_q[tail_q]   <= PC4;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      irvalid_q <= 1'b0;
      instr_q   <= '0;
      pc4_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      irvalid_q <= irvalid_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
    end
  end

  // The decoded outputs are plain slices of the output register, so there is
  // no path from IDataOut to any output.
  assign IReady    = !full;
  assign IRValid   = irvalid_q;
  assign Count     = count_q;
  assign op        = instr_q[31:26];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rd        = instr_q[15:11];
  assign Immediate = instr_q[15:0];
  assign Sa        = instr_q[10:6];
  assign InstrPC4  = pc4_q;
  assign JumpPC    = {pc4_q[ADDR_W-1:28], instr_q[25:0], 2'b00};

endmodule
